// File: rtl/byte_word_packer.sv
// Packs a byte stream LSB-first into BYTES_PER_WORD-byte words behind a one-word output register, 1-cycle latency;
// in_ready drops only when the last slot or a pending flush waits on a full output register. Option: BYTE_WORD_PACKER_PARITY_EN.
module byte_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int CW             = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [CW-1:0]               out_count,
  output logic                        out_last,
`ifdef BYTE_WORD_PACKER_PARITY_EN
  output logic                        out_parity,
`endif
  input  logic                        out_ready
);

  localparam int            IW        = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST_SLOT = CW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    PEND
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  fill_q, fill_d;
  logic [BYTES_PER_WORD-1:0][7:0] acc_q, acc_d;

  logic                        flush_pend;
  logic                        can_load;
  logic                        take;
  logic                        flush_hit;
  logic                        load;
  logic                        load_last;
  logic [CW-1:0]               new_count;
  logic [CW-1:0]               load_count;
  logic [8*BYTES_PER_WORD-1:0] word;

  assign flush_pend = (state_q == PEND);
  assign can_load   = !out_valid || out_ready;
  // Slots below the last never need the output register, so they always accept.
  assign in_ready   = !flush_pend && ((fill_q < LAST_SLOT) || can_load);
  assign take       = in_valid && in_ready;
  assign new_count  = fill_q + CW'(take);
  assign flush_hit  = flush && (new_count != '0);

  // Candidate word: held bytes, the byte accepted this cycle, zero padding above.
  always_comb begin
    word = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (CW'(k) < fill_q) begin
        word[8*k +: 8] = acc_q[k];
      end else if (take && (CW'(k) == fill_q)) begin
        word[8*k +: 8] = in_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    load       = 1'b0;
    load_last  = 1'b0;
    load_count = '0;
    case (state_q)
      EMPTY, PARTIAL: begin
        if (take) begin
          acc_d[fill_q[IW-1:0]] = in_data;
        end
        // A completing byte implies can_load, since in_ready gated it.
        if ((take && (fill_q == LAST_SLOT)) || (flush_hit && can_load)) begin
          load       = 1'b1;
          load_last  = flush;
          load_count = new_count;
          fill_d     = '0;
          state_d    = EMPTY;
        end else begin
          fill_d = new_count;
          if (flush_hit) begin
            state_d = PEND;
          end else if (new_count != '0) begin
            state_d = PARTIAL;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      PEND: begin
        if (can_load) begin
          load       = 1'b1;
          load_last  = 1'b1;
          load_count = fill_q;
          fill_d     = '0;
          state_d    = EMPTY;
        end
      end
      default: begin
        fill_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      fill_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
`ifdef BYTE_WORD_PACKER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= word;
      out_count  <= load_count;
      out_last   <= load_last;
`ifdef BYTE_WORD_PACKER_PARITY_EN
      // Padding is zero, so the full-word XOR equals the valid-byte XOR.
      out_parity <= ^word;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer: directed scenarios plus randomized traffic against a queue-based model.
module tb_byte_word_packer;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_ready;
  logic           flush = 1'b0;
  logic           out_valid;
  logic [8*N-1:0] out_data;
  logic [CW-1:0]  out_count;
  logic           out_last;
  logic           out_ready = 1'b0;
`ifdef BYTE_WORD_PACKER_PARITY_EN
  logic           out_parity;
`endif

  always #5 clk = ~clk;

  byte_word_packer #(.BYTES_PER_WORD(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last),
`ifdef BYTE_WORD_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accumulator as a byte queue plus one output slot.
  logic [7:0]     m_acc[$];
  bit             m_pend = 0;
  bit             m_ov   = 0;
  bit             m_ol   = 0;
  bit             m_op   = 0;
  logic [8*N-1:0] m_od   = '0;
  int             m_oc   = 0;
  bit             obs_rdy, exp_rdy;

  task automatic model_clear();
    m_acc.delete();
    m_pend = 0;
    m_ov   = 0;
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model, return at the next negedge.
  task automatic step(input bit iv, input logic [7:0] id, input bit fl, input bit ordy);
    bit can_load, take, ld, last;
    logic [8*N-1:0] w;
    in_valid = iv; in_data = id; flush = fl; out_ready = ordy;
    #1;
    obs_rdy  = in_ready;
    can_load = !m_ov || ordy;
    exp_rdy  = !m_pend && ((m_acc.size() < N - 1) || can_load);
    take     = iv && exp_rdy;
    ld = 0; last = 0;
    if (m_pend) begin
      ld = can_load; last = 1;
    end else begin
      if (take) m_acc.push_back(id);
      if (m_acc.size() == N) begin
        ld = 1; last = fl;
      end else if (fl && m_acc.size() > 0) begin
        if (can_load) begin ld = 1; last = 1; end
        else m_pend = 1;
      end
    end
    if (ld) begin
      w = '0;
      foreach (m_acc[i]) w[8*i +: 8] = m_acc[i];
      m_od = w; m_oc = m_acc.size(); m_ol = last; m_op = ^w; m_ov = 1;
      m_acc.delete(); m_pend = 0;
    end else if (ordy) begin
      m_ov = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_checks++; if (out_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef BYTE_WORD_PACKER_PARITY_EN
    n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", out_parity); end
`endif
    rst = 0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [7:0] bytes_q[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (bytes_q[i]) begin
      step(1, bytes_q[i], 0, 1);
      n_checks++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL full_in_ready[%0d]: got %b want 1", i, obs_rdy); end
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 32'h44332211) begin n_fail++; $display("FAIL full_data: got %h want 44332211", out_data); end
    n_checks++; if (out_count !== CW'(4)) begin n_fail++; $display("FAIL full_count: got %0d want 4", out_count); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL full_last: got %b want 0", out_last); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_flush();
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(0, 8'h00, 1, 1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL flush_data: got %h want 0000bbaa", out_data); end
    n_checks++; if (out_count !== CW'(2)) begin n_fail++; $display("FAIL flush_count: got %0d want 2", out_count); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL flush_last: got %b want 1", out_last); end
    step(0, 8'h00, 1, 1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_ignored: got valid %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    n_checks++; if (out_data !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL bp_first: got %h want a3a2a1a0", out_data); end
    for (int i = 0; i < 3; i++) begin
      step(1, 8'hB0 + 8'(i), 0, 0);
      n_checks++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_low_slot_ready[%0d]: got %b want 1", i, obs_rdy); end
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 8'hB3, 0, 0);
      n_checks++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_last_slot_ready[%0d]: got %b want 0", i, obs_rdy); end
      n_checks++; if (out_data !== 32'hA3A2A1A0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable[%0d]: got %b/%h want 1/a3a2a1a0", i, out_valid, out_data); end
    end
    step(1, 8'hB3, 0, 1);
    n_checks++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", obs_rdy); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hB3B2B1B0) begin n_fail++; $display("FAIL bp_reload: got %b/%h want 1/b3b2b1b0", out_valid, out_data); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_flush_last();
    for (int i = 1; i <= 3; i++) step(1, 8'(i), 0, 1);
    step(1, 8'h04, 1, 1);
    n_checks++; if (out_data !== 32'h04030201) begin n_fail++; $display("FAIL flast_data: got %h want 04030201", out_data); end
    n_checks++; if (out_count !== CW'(4)) begin n_fail++; $display("FAIL flast_count: got %0d want 4", out_count); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL flast_last: got %b want 1", out_last); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_pend();
    for (int i = 0; i < 4; i++) step(1, 8'hD0 + 8'(i), 0, 0);
    step(1, 8'hC0, 0, 0);
    step(1, 8'hC1, 0, 0);
    step(0, 8'h00, 1, 0);
    n_checks++; if (out_data !== 32'hD3D2D1D0) begin n_fail++; $display("FAIL pend_hold: got %h want d3d2d1d0", out_data); end
    step(1, 8'hEE, 0, 0);
    n_checks++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL pend_in_ready: got %b want 0", obs_rdy); end
    step(0, 8'h00, 0, 1);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000C1C0) begin n_fail++; $display("FAIL pend_emit: got %b/%h want 1/0000c1c0", out_valid, out_data); end
    n_checks++; if (out_count !== CW'(2) || out_last !== 1'b1) begin n_fail++; $display("FAIL pend_flags: got count %0d last %b want 2/1", out_count, out_last); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) step(1, 8'hE0 + 8'(i), 0, 0);
    step(1, 8'h99, 0, 0);
    step(1, 8'h98, 0, 0);
    in_valid = 0;
    rst = 1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL mrst_out: got %b/%h want 0/0", out_valid, out_data); end
    n_checks++; if (out_count !== '0 || out_last !== 1'b0) begin n_fail++; $display("FAIL mrst_flags: got %0d/%b want 0/0", out_count, out_last); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 0;
    model_clear();
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1, 8'h55 + 8'(i), 0, 1);
    n_checks++; if (out_data !== 32'h58575655 || out_count !== CW'(4)) begin n_fail++; $display("FAIL mrst_word: got %h/%0d want 58575655/4", out_data, out_count); end
    step(0, 8'h00, 0, 1);
  endtask

`ifdef BYTE_WORD_PACKER_PARITY_EN
  task automatic test_parity();
    step(1, 8'h01, 1, 1);
    n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_01: got %b want 1", out_parity); end
    step(1, 8'h03, 1, 1);
    n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_03: got %b want 0", out_parity); end
    step(0, 8'h00, 0, 1);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int ordy_pct;
      ordy_pct = ((c / 400) % 2 == 1) ? 30 : 90;
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) < ordy_pct);
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready @%0d: got %b want %b", c, obs_rdy, exp_rdy); end
      n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", c, out_valid, m_ov); end
      if (m_ov) begin
        n_checks++;
        if (out_data !== m_od || out_count !== CW'(m_oc) || out_last !== m_ol) begin
          n_fail++;
          $display("FAIL rnd_word @%0d: got %h/%0d/%b want %h/%0d/%b", c, out_data, out_count, out_last, m_od, m_oc, m_ol);
        end
`ifdef BYTE_WORD_PACKER_PARITY_EN
        n_checks++; if (out_parity !== m_op) begin n_fail++; $display("FAIL rnd_parity @%0d: got %b want %b", c, out_parity, m_op); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_backpressure();
    test_flush_last();
    test_pend();
    test_mid_reset();
`ifdef BYTE_WORD_PACKER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
